// File: rtl/ir_byte_unloader.sv
// Splits a 16-bit instruction-register word into two byte beats on a
// valid/ready stream, with selectable byte order and a delivered-word counter.
module ir_byte_unloader #(
  parameter bit HI_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [7:0]  out_data,
  output logic        out_lh,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [7:0]  word_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] hold;
  logic [7:0]  count;
  logic        accept;
  logic        word_done;
  logic        second;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake decode; flush overrides every handshake
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    word_done = 1'b0;

    in_ready  = !flush && ((state == IDLE) || ((state == SECOND) && out_ready));
    accept    = in_valid && in_ready;
    word_done = (state == SECOND) && out_ready && !flush;

    case (state)
      IDLE: begin
        if (accept) state_nxt = FIRST;
      end
      FIRST: begin
        if (out_ready) state_nxt = SECOND;
      end
      SECOND: begin
        if (out_ready) state_nxt = accept ? FIRST : IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (flush) state_nxt = IDLE;
  end

  // Hold register: loaded on acceptance, cleared when the word is flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= 16'h0000;
    end else if (flush) begin
      hold <= 16'h0000;
    end else if (accept) begin
      hold <= in_data;
    end
  end

  // Delivered-word counter, wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'h00;
    end else if (word_done) begin
      count <= count + 8'd1;
    end
  end

  // Byte outputs decode straight from the state and hold flops
  assign second     = (state == SECOND);
  assign out_valid  = (state != IDLE);
  assign out_last   = second;
  assign out_lh     = HI_FIRST ^ second;
  assign out_data   = out_lh ? hold[15:8] : hold[7:0];
  assign word_count = count;

endmodule

// File: tb/tb_ir_byte_unloader.sv
// Bench for ir_byte_unloader: both byte orders driven from shared stimulus,
// directed scenarios plus a randomized run against a byte-queue reference model.
module tb_ir_byte_unloader;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic        ir0, ov0, lh0, ol0;
  logic [7:0]  od0, wc0;
  logic        ir1, ov1, lh1, ol1;
  logic [7:0]  od1, wc1;

  int checks;
  int failures;

  // Reference model: the word in flight and how many of its bytes remain
  logic [15:0] m_word;
  int          m_left;
  int          m_count;

  ir_byte_unloader #(.HI_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir0), .flush(flush), .out_data(od0), .out_lh(lh0),
    .out_valid(ov0), .out_ready(out_ready), .out_last(ol0), .word_count(wc0)
  );

  ir_byte_unloader #(.HI_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir1), .flush(flush), .out_data(od1), .out_lh(lh1),
    .out_valid(ov1), .out_ready(out_ready), .out_last(ol1), .word_count(wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_in_ready();
    return !flush && ((m_left == 0) || ((m_left == 1) && out_ready));
  endfunction

  // {lh, last, data} of the byte currently presented
  function automatic logic [9:0] exp_byte(input logic hi);
    int   idx;
    logic upper;
    idx   = 2 - m_left;
    upper = hi ? (idx == 0) : (idx == 1);
    return {hi ^ (idx == 1), (idx == 1), upper ? m_word[15:8] : m_word[7:0]};
  endfunction

  function automatic void model_clear();
    m_word  = 16'h0000;
    m_left  = 0;
    m_count = 0;
  endfunction

  // Advance the model by the rising edge that consumed the current inputs
  function automatic void model_step();
    logic rdy;
    if (!rst_n) begin
      model_clear();
      return;
    end
    rdy = exp_in_ready();
    if (flush) begin
      m_left = 0;
      m_word = 16'h0000;
      return;
    end
    if ((m_left > 0) && out_ready) begin
      m_left = m_left - 1;
      if (m_left == 0) m_count = (m_count + 1) % 256;
    end
    if (in_valid && rdy) begin
      m_word = in_data;
      m_left = 2;
    end
  endfunction

  // Account for the edge just passed, apply new inputs, let comb logic settle
  task automatic drive(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    model_step();
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; flush = 1'b0; out_ready = 1'b0;
    model_clear();
    #3;
    checks++;
    if ({ov0, ol0, lh0, od0, wc0} !== {1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL reset_dut0 got v/last/lh/data/cnt=%b/%b/%b/%h/%h want 0/0/0/00/00", ov0, ol0, lh0, od0, wc0);
    end
    checks++;
    if ({ov1, ol1, lh1, od1, wc1} !== {1'b0, 1'b0, 1'b1, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL reset_dut1 got v/last/lh/data/cnt=%b/%b/%b/%h/%h want 0/0/1/00/00", ov1, ol1, lh1, od1, wc1);
    end
    checks++;
    if ({ir0, ir1} !== 2'b11) begin
      failures++;
      $display("FAIL reset_in_ready got %b%b want 11", ir0, ir1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    drive(1'b1, 16'hA55A, 1'b1, 1'b0);
    drive(1'b0, 16'hFFFF, 1'b1, 1'b0);
    checks++;
    if ({ov0, lh0, ol0, od0} !== {1'b1, 1'b0, 1'b0, 8'h5A}) begin
      failures++;
      $display("FAIL a55a_first_lo got v/lh/last/data=%b/%b/%b/%h want 1/0/0/5a", ov0, lh0, ol0, od0);
    end
    checks++;
    if ({ov1, lh1, ol1, od1} !== {1'b1, 1'b1, 1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL a55a_first_hi got v/lh/last/data=%b/%b/%b/%h want 1/1/0/a5", ov1, lh1, ol1, od1);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if ({ov0, lh0, ol0, od0} !== {1'b1, 1'b1, 1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL a55a_second_lo got v/lh/last/data=%b/%b/%b/%h want 1/1/1/a5", ov0, lh0, ol0, od0);
    end
    drive(1'b1, 16'h1234, 1'b1, 1'b0);
    checks++;
    if ({ov0, wc0, wc1} !== {1'b0, 8'd1, 8'd1}) begin
      failures++;
      $display("FAIL a55a_done got v/cnt0/cnt1=%b/%0d/%0d want 0/1/1", ov0, wc0, wc1);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if ({ov1, lh1, ol1, od1} !== {1'b1, 1'b1, 1'b0, 8'h12}) begin
      failures++;
      $display("FAIL h1234_first_hi got v/lh/last/data=%b/%b/%b/%h want 1/1/0/12", ov1, lh1, ol1, od1);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if ({ov1, lh1, ol1, od1} !== {1'b1, 1'b0, 1'b1, 8'h34}) begin
      failures++;
      $display("FAIL h1234_second_hi got v/lh/last/data=%b/%b/%b/%h want 1/0/1/34", ov1, lh1, ol1, od1);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [4];
    logic [7:0] c0;
    exp_seq[0] = 8'h02; exp_seq[1] = 8'h01; exp_seq[2] = 8'h04; exp_seq[3] = 8'h03;
    c0 = wc0;
    drive(1'b1, 16'h0102, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive((i < 2), 16'h0304, 1'b1, 1'b0);
      checks++;
      if ({ov0, od0, ir0} !== {1'b1, exp_seq[i], (i == 1 || i == 3)}) begin
        failures++;
        $display("FAIL b2b_beat%0d got v/data/in_ready=%b/%h/%b want 1/%h/%b", i, ov0, od0, ir0, exp_seq[i], (i == 1 || i == 3));
      end
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if ({ov0, wc0} !== {1'b0, 8'(c0 + 8'd2)}) begin
      failures++;
      $display("FAIL b2b_count got v/cnt=%b/%0d want 0/%0d", ov0, wc0, 8'(c0 + 8'd2));
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'($urandom), 1'b0, 1'b0);
      checks++;
      if ({ov0, lh0, ol0, od0, ir0, ov1, lh1, od1} !== {1'b1, 1'b0, 1'b0, 8'hEF, 1'b0, 1'b1, 1'b1, 8'hBE}) begin
        failures++;
        $display("FAIL stall_cycle%0d got v/lh/last/data/in_ready=%b/%b/%b/%h/%b hi=%h want 1/0/0/ef/0 hi=be", i, ov0, lh0, ol0, od0, ir0, od1);
      end
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if ({ov0, ol0, od0} !== {1'b1, 1'b1, 8'hBE}) begin
      failures++;
      $display("FAIL stall_second got v/last/data=%b/%b/%h want 1/1/be", ov0, ol0, od0);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if ({ov0, wc0} !== {1'b0, 8'(m_count)}) begin
      failures++;
      $display("FAIL stall_done got v/cnt=%b/%0d want 0/%0d", ov0, wc0, m_count);
    end
  endtask

  task automatic test_flush();
    logic [7:0] c0;
    c0 = wc0;
    drive(1'b1, 16'hC3D4, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b1, 16'h7777, 1'b1, 1'b1);
    checks++;
    if ({ov0, ol0, ir0, ir1} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush_second got v/last/in_ready=%b/%b/%b%b want 1/1/00", ov0, ol0, ir0, ir1);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if ({ov0, ov1, wc0, wc1} !== {1'b0, 1'b0, c0, c0}) begin
      failures++;
      $display("FAIL flush_after got v0/v1/cnt0/cnt1=%b/%b/%0d/%0d want 0/0/%0d/%0d", ov0, ov1, wc0, wc1, c0, c0);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    pulse_reset();
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 16'($urandom), 1'b1, 1'b0);
    end
    checks++;
    if ({ov0, ol0, wc0} !== {1'b1, 1'b0, 8'd255}) begin
      failures++;
      $display("FAIL wrap_255 got v/last/cnt=%b/%b/%0d want 1/0/255", ov0, ol0, wc0);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if ({ov0, wc0, wc1} !== {1'b0, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL wrap_zero got v/cnt0/cnt1=%b/%0d/%0d want 0/0/0", ov0, wc0, wc1);
    end
    drive(1'b1, 16'h9876, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov0, ol0, lh0, od0, ov1, lh1, od1} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL async_reset got v/last/lh/data=%b/%b/%b/%h hi v/lh/data=%b/%b/%h want 0/0/0/00 0/1/00", ov0, ol0, lh0, od0, ov1, lh1, od1);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if ({ov0, ir0, wc0} !== {1'b0, 1'b1, 8'd0}) begin
      failures++;
      $display("FAIL after_reset got v/in_ready/cnt=%b/%b/%0d want 0/1/0", ov0, ir0, wc0);
    end
  endtask

  task automatic test_random();
    logic [9:0] e0, e1;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
      checks++;
      if ({ov0, ov1, ir0, ir1, wc0, wc1} !== {(m_left > 0), (m_left > 0), exp_in_ready(), exp_in_ready(), 8'(m_count), 8'(m_count)}) begin
        failures++;
        $display("FAIL rand_ctrl cyc%0d got v=%b%b rdy=%b%b cnt=%0d/%0d want v=%0b rdy=%b cnt=%0d", i, ov0, ov1, ir0, ir1, wc0, wc1, (m_left > 0), exp_in_ready(), m_count);
      end
      if (m_left > 0) begin
        e0 = exp_byte(1'b0);
        e1 = exp_byte(1'b1);
        checks++;
        if ({lh0, ol0, od0, lh1, ol1, od1} !== {e0, e1}) begin
          failures++;
          $display("FAIL rand_byte cyc%0d got lo=%b/%b/%h hi=%b/%b/%h want lo=%b/%b/%h hi=%b/%b/%h", i, lh0, ol0, od0, lh1, ol1, od1, e0[9], e0[8], e0[7:0], e1[9], e1[8], e1[7:0]);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_flush();
    test_wrap_and_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
